core_mem_bridge: RTL

- Sits between the K8088 core byte bus (address/in/out/we/ce) and a 16-bit word-wide external memory with a req/ack handshake.
- Converts byte accesses into word accesses with byte enables.
- Stalls the core through its ce input until each access completes.
- Holds a one-word read buffer, so sequential byte fetches within the same word complete in one cycle without a memory access.

---
 rtl/core_mem_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/core_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_bridge
//  Description : Byte-wide core bus to 16-bit req/ack memory bridge with a
//                one-word read buffer. Stalls the core via core_ce until
//                each memory access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_bridge #(
   parameter int BUFFER_EN = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [19:0] core_address,
   input  logic [7:0]  core_out,
   input  logic        core_we,
   output logic [7:0]  core_in,
   output logic        core_ce,
   output logic [18:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_be,
   output logic        mem_we,
   output logic        mem_req,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   localparam logic BUF_ON = (BUFFER_EN != 0);

   logic [1:0]  state_q,       state_d;
   logic [7:0]  core_in_q,     core_in_d;
   logic [18:0] mem_address_q, mem_address_d;
   logic [15:0] mem_wdata_q,   mem_wdata_d;
   logic [1:0]  mem_be_q,      mem_be_d;
   logic        mem_we_q,      mem_we_d;
   logic        mem_req_q,     mem_req_d;
   logic [15:0] buf_data_q,    buf_data_d;
   logic [18:0] buf_tag_q,     buf_tag_d;
   logic        buf_valid_q,   buf_valid_d;

   logic        buf_hit;
   logic        tag_match_wr;

   // Buffer lookup for the core's current address and for the pending write
   always_comb begin
      buf_hit      = BUF_ON && buf_valid_q && (buf_tag_q == core_address[19:1]);
      tag_match_wr = buf_valid_q && (buf_tag_q == mem_address_q);
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         core_in_q     <= 8'h00;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_be_q      <= 2'b00;
         mem_we_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         buf_data_q    <= '0;
         buf_tag_q     <= '0;
         buf_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         core_in_q     <= core_in_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_q      <= mem_be_d;
         mem_we_q      <= mem_we_d;
         mem_req_q     <= mem_req_d;
         buf_data_q    <= buf_data_d;
         buf_tag_q     <= buf_tag_d;
         buf_valid_q   <= buf_valid_d;
      end
   end

   // Next-state: writes and read misses go to memory, hits stay in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (core_we)       state_d = ST_WRITE;
            else if (!buf_hit) state_d = ST_READ;
         end
         ST_READ, ST_WRITE: begin
            if (mem_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Core enable: only combinational output, depends on state, hit and ack
   always_comb begin
      core_ce = 1'b0;
      case (state_q)
         ST_IDLE:           core_ce = !core_we && buf_hit;
         ST_READ, ST_WRITE: core_ce = mem_ack;
         default:           core_ce = 1'b0;
      endcase
   end

   // Datapath: launch memory requests, capture read data, maintain buffer
   always_comb begin
      core_in_d     = core_in_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_d      = mem_be_q;
      mem_we_d      = mem_we_q;
      mem_req_d     = mem_req_q;
      buf_data_d    = buf_data_q;
      buf_tag_d     = buf_tag_q;
      buf_valid_d   = buf_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (core_we) begin
               mem_address_d = core_address[19:1];
               mem_wdata_d   = {core_out, core_out};
               mem_be_d      = core_address[0] ? 2'b10 : 2'b01;
               mem_we_d      = 1'b1;
               mem_req_d     = 1'b1;
            end else if (buf_hit) begin
               core_in_d = core_address[0] ? buf_data_q[15:8] : buf_data_q[7:0];
            end else begin
               mem_address_d = core_address[19:1];
               mem_we_d      = 1'b0;
               mem_be_d      = 2'b11;
               mem_req_d     = 1'b1;
            end
         end
         ST_READ: begin
            if (mem_ack) begin
               core_in_d   = core_address[0] ? mem_rdata[15:8] : mem_rdata[7:0];
               buf_data_d  = mem_rdata;
               buf_tag_d   = mem_address_q;
               buf_valid_d = BUF_ON;
               mem_req_d   = 1'b0;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               // Write-through keeps the buffered word coherent with memory
               if (tag_match_wr) begin
                  if (mem_be_q[0]) buf_data_d[7:0]  = mem_wdata_q[7:0];
                  if (mem_be_q[1]) buf_data_d[15:8] = mem_wdata_q[15:8];
               end
            end
         end
         default: ;
      endcase
   end

   assign core_in     = core_in_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign mem_we      = mem_we_q;
   assign mem_req     = mem_req_q;

endmodule
`default_nettype wire
